// File: rtl/riscv_pkg.sv
// RV32I decode vocabulary shared by the decode stage: operation classes,
// base opcodes, immediate formats and the immediate assembler.
package riscv_pkg;

  typedef enum logic [3:0] {
    OC_ILLEGAL = 4'd0,
    OC_LUI     = 4'd1,
    OC_AUIPC   = 4'd2,
    OC_JAL     = 4'd3,
    OC_JALR    = 4'd4,
    OC_BRANCH  = 4'd5,
    OC_LOAD    = 4'd6,
    OC_STORE   = 4'd7,
    OC_OPIMM   = 4'd8,
    OC_OP      = 4'd9,
    OC_FENCE   = 4'd10,
    OC_SYSTEM  = 4'd11
  } opclass_t;

  typedef enum logic [2:0] {
    FMT_NONE = 3'd0,
    FMT_I    = 3'd1,
    FMT_S    = 3'd2,
    FMT_B    = 3'd3,
    FMT_U    = 3'd4,
    FMT_J    = 3'd5
  } imm_fmt_t;

  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_FENCE  = 7'b0001111;
  localparam logic [6:0] OPC_SYSTEM = 7'b1110011;

  function automatic logic [31:0] imm_gen(input imm_fmt_t fmt, input logic [31:0] instr);
    logic [31:0] imm;
    case (fmt)
      FMT_I:   imm = {{20{instr[31]}}, instr[31:20]};
      FMT_S:   imm = {{20{instr[31]}}, instr[31:25], instr[11:7]};
      FMT_B:   imm = {{20{instr[31]}}, instr[7], instr[30:25], instr[11:8], 1'b0};
      FMT_U:   imm = {instr[31:12], 12'b0};
      FMT_J:   imm = {{12{instr[31]}}, instr[19:12], instr[20], instr[30:21], 1'b0};
      default: imm = 32'h0000_0000;
    endcase
    return imm;
  endfunction

endpackage

// File: rtl/id_decode.sv
// Combinational RV32I field decoder: opcode -> class, immediate, rd presence.
module id_decode import riscv_pkg::*; (
  input  logic [31:0] instr,
  output opclass_t    opclass,
  output logic [31:0] imm,
  output logic        rd_valid,
  output logic        illegal
);

  imm_fmt_t fmt;
  logic     unused_funct3_s;

  // Classify the opcode; anything unrecognised (including [1:0]!=2'b11) is illegal.
  always_comb begin
    opclass  = OC_ILLEGAL;
    fmt      = FMT_NONE;
    rd_valid = 1'b0;
    illegal  = 1'b0;
    case (instr[6:0])
      OPC_LUI:    begin opclass = OC_LUI;    fmt = FMT_U; rd_valid = 1'b1; end
      OPC_AUIPC:  begin opclass = OC_AUIPC;  fmt = FMT_U; rd_valid = 1'b1; end
      OPC_JAL:    begin opclass = OC_JAL;    fmt = FMT_J; rd_valid = 1'b1; end
      OPC_JALR:   begin opclass = OC_JALR;   fmt = FMT_I; rd_valid = 1'b1; end
      OPC_BRANCH: begin opclass = OC_BRANCH; fmt = FMT_B; end
      OPC_LOAD:   begin opclass = OC_LOAD;   fmt = FMT_I; rd_valid = 1'b1; end
      OPC_STORE:  begin opclass = OC_STORE;  fmt = FMT_S; end
      OPC_OPIMM:  begin opclass = OC_OPIMM;  fmt = FMT_I; rd_valid = 1'b1; end
      OPC_OP:     begin opclass = OC_OP;     rd_valid = 1'b1; end
      OPC_FENCE:  begin opclass = OC_FENCE; end
      OPC_SYSTEM: begin opclass = OC_SYSTEM; rd_valid = 1'b1; end
      default:    begin illegal = 1'b1; end
    endcase
  end

  assign imm = imm_gen(fmt, instr);
  assign unused_funct3_s = ^instr[14:12];

endmodule

// File: rtl/id_stage.sv
// Decode stage between fetch and execute: drives register file reads, aligns decoded
// fields with the 1-cycle registered read data, and bypasses same-cycle writebacks.
module id_stage import riscv_pkg::*; #(
  parameter int W       = 32,
  parameter int XLEN_PC = 32
) (
  input  logic               clk,
  input  logic               nrst,
  input  logic               if_valid,
  output logic               if_ready,
  input  logic [31:0]        if_instr,
  input  logic [XLEN_PC-1:0] if_pc,
  input  logic               flush,
  output logic [4:0]         rf_radd1,
  output logic [4:0]         rf_radd2,
  input  logic [W-1:0]       rf_rs1,
  input  logic [W-1:0]       rf_rs2,
  input  logic               wb_wen,
  input  logic [4:0]         wb_wadd,
  input  logic [W-1:0]       wb_wdata,
  output logic               id_valid,
  input  logic               id_ready,
  output logic [XLEN_PC-1:0] id_pc,
  output logic [W-1:0]       id_op_a,
  output logic [W-1:0]       id_op_b,
  output logic [W-1:0]       id_imm,
  output logic [4:0]         id_rd,
  output opclass_t           id_opclass,
  output logic [2:0]         id_funct3,
  output logic               id_funct7b5,
  output logic               id_illegal
);

  opclass_t           dec_opclass_s;
  logic [31:0]        dec_imm_s;
  logic               dec_rd_valid_s, dec_illegal_s, load_s, unused_instr_s;
  logic               valid_d, valid_q, illegal_d, illegal_q;
  logic               hit1_d, hit1_q, hit2_d, hit2_q;
  logic [31:0]        instr_d, instr_q;
  logic [XLEN_PC-1:0] pc_d, pc_q;
  logic [W-1:0]       imm_d, imm_q, bdata1_d, bdata1_q, bdata2_d, bdata2_q;
  logic [4:0]         rd_d, rd_q;
  opclass_t           opclass_d, opclass_q;

  id_decode u_decode (
    .instr    (if_instr),
    .opclass  (dec_opclass_s),
    .imm      (dec_imm_s),
    .rd_valid (dec_rd_valid_s),
    .illegal  (dec_illegal_s)
  );

  assign if_ready = !valid_q || id_ready;
  assign load_s   = if_valid && if_ready;
  // While stalled the held sources are re-read so operands stay current.
  assign rf_radd1 = load_s ? if_instr[19:15] : instr_q[19:15];
  assign rf_radd2 = load_s ? if_instr[24:20] : instr_q[24:20];

  // Next-state: flush beats load beats drain; bypass tracks writebacks every cycle.
  always_comb begin
    valid_d   = valid_q;
    instr_d   = instr_q;
    pc_d      = pc_q;
    imm_d     = imm_q;
    rd_d      = rd_q;
    opclass_d = opclass_q;
    illegal_d = illegal_q;
    if (flush) begin
      valid_d = 1'b0;
    end else if (load_s) begin
      valid_d   = 1'b1;
      instr_d   = if_instr;
      pc_d      = if_pc;
      imm_d     = W'($signed(dec_imm_s));
      rd_d      = dec_rd_valid_s ? if_instr[11:7] : 5'd0;
      opclass_d = dec_opclass_s;
      illegal_d = dec_illegal_s;
    end else if (id_ready) begin
      valid_d = 1'b0;
    end else begin
      valid_d = valid_q;
    end
    hit1_d   = wb_wen && (wb_wadd != 5'd0) && (wb_wadd == rf_radd1);
    hit2_d   = wb_wen && (wb_wadd != 5'd0) && (wb_wadd == rf_radd2);
    bdata1_d = wb_wdata;
    bdata2_d = wb_wdata;
  end

  // Stage and bypass registers.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      valid_q   <= 1'b0;
      instr_q   <= 32'h0000_0000;
      pc_q      <= '0;
      imm_q     <= '0;
      rd_q      <= 5'd0;
      opclass_q <= OC_ILLEGAL;
      illegal_q <= 1'b0;
      hit1_q    <= 1'b0;
      hit2_q    <= 1'b0;
      bdata1_q  <= '0;
      bdata2_q  <= '0;
    end else begin
      valid_q   <= valid_d;
      instr_q   <= instr_d;
      pc_q      <= pc_d;
      imm_q     <= imm_d;
      rd_q      <= rd_d;
      opclass_q <= opclass_d;
      illegal_q <= illegal_d;
      hit1_q    <= hit1_d;
      hit2_q    <= hit2_d;
      bdata1_q  <= bdata1_d;
      bdata2_q  <= bdata2_d;
    end
  end

  assign id_valid    = valid_q;
  assign id_pc       = pc_q;
  assign id_op_a     = hit1_q ? bdata1_q : rf_rs1;
  assign id_op_b     = hit2_q ? bdata2_q : rf_rs2;
  assign id_imm      = imm_q;
  assign id_rd       = rd_q;
  assign id_opclass  = opclass_q;
  assign id_funct3   = instr_q[14:12];
  assign id_funct7b5 = instr_q[30];
  assign id_illegal  = illegal_q;
  assign unused_instr_s = ^{instr_q[31], instr_q[29:25], instr_q[11:0]};

endmodule

// File: tb/tb_id_stage.sv
// Self-checking bench for id_stage: decode vector table, directed handshake/bypass
// sequences, and randomized traffic against an architectural reference model.
module tb_id_stage;
  import riscv_pkg::*;

  localparam int W = 32;
  localparam int XLEN_PC = 32;

  logic clk = 1'b0;
  logic nrst, if_valid, if_ready, flush, wb_wen, id_valid, id_ready, id_funct7b5, id_illegal;
  logic [31:0] if_instr, if_pc, rf_rs1, rf_rs2, wb_wdata, id_pc, id_op_a, id_op_b, id_imm;
  logic [4:0] rf_radd1, rf_radd2, wb_wadd, id_rd;
  logic [2:0] id_funct3;
  opclass_t id_opclass;

  always #5 clk = ~clk;

  id_stage #(.W(W), .XLEN_PC(XLEN_PC)) dut (
    .clk(clk), .nrst(nrst), .if_valid(if_valid), .if_ready(if_ready), .if_instr(if_instr),
    .if_pc(if_pc), .flush(flush), .rf_radd1(rf_radd1), .rf_radd2(rf_radd2),
    .rf_rs1(rf_rs1), .rf_rs2(rf_rs2), .wb_wen(wb_wen), .wb_wadd(wb_wadd),
    .wb_wdata(wb_wdata), .id_valid(id_valid), .id_ready(id_ready), .id_pc(id_pc),
    .id_op_a(id_op_a), .id_op_b(id_op_b), .id_imm(id_imm), .id_rd(id_rd),
    .id_opclass(id_opclass), .id_funct3(id_funct3), .id_funct7b5(id_funct7b5),
    .id_illegal(id_illegal)
  );

  // Register file environment: registered read returning the pre-write value, x0 fixed.
  logic [31:0] rf_mem [32] = '{default: 32'h0};
  always @(posedge clk) begin
    rf_rs1 <= rf_mem[rf_radd1];
    rf_rs2 <= rf_mem[rf_radd2];
    if (wb_wen && wb_wadd != 5'd0) rf_mem[wb_wadd] <= wb_wdata;
  end

  // Reference model: architectural registers plus the bundle execute should see.
  logic [31:0] arch [32];
  logic        exp_valid;
  logic [31:0] exp_instr, exp_pc;
  int n_vec = 0;
  int n_bad = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic void ref_decode(input logic [31:0] i, output opclass_t oc,
                                     output logic [31:0] imm, output logic [4:0] rd,
                                     output logic ill);
    logic [31:0] sx;
    int fmt;
    sx  = i[31] ? 32'hFFFF_FFFF : 32'h0;
    ill = 1'b0;
    fmt = 0;
    rd  = i[11:7];
    case (i[6:0])
      7'h37:   begin oc = OC_LUI;    fmt = 4; end
      7'h17:   begin oc = OC_AUIPC;  fmt = 4; end
      7'h6F:   begin oc = OC_JAL;    fmt = 5; end
      7'h67:   begin oc = OC_JALR;   fmt = 1; end
      7'h63:   begin oc = OC_BRANCH; fmt = 3; rd = 5'd0; end
      7'h03:   begin oc = OC_LOAD;   fmt = 1; end
      7'h23:   begin oc = OC_STORE;  fmt = 2; rd = 5'd0; end
      7'h13:   begin oc = OC_OPIMM;  fmt = 1; end
      7'h33:   begin oc = OC_OP; end
      7'h0F:   begin oc = OC_FENCE;  rd = 5'd0; end
      7'h73:   begin oc = OC_SYSTEM; end
      default: begin oc = OC_ILLEGAL; ill = 1'b1; rd = 5'd0; end
    endcase
    case (fmt)
      1: imm = (sx << 12) | (i >> 20);
      2: imm = (sx << 12) | ((i >> 25) << 5) | ((i >> 7) & 32'h1F);
      3: imm = (sx << 12) | (((i >> 7) & 32'h1) << 11) | (((i >> 25) & 32'h3F) << 5)
               | (((i >> 8) & 32'hF) << 1);
      4: imm = i & 32'hFFFF_F000;
      5: imm = (sx << 20) | (i & 32'h000F_F000) | (((i >> 20) & 32'h1) << 11)
               | (((i >> 21) & 32'h3FF) << 1);
      default: imm = 32'h0;
    endcase
  endfunction

  task automatic check_bundle();
    opclass_t oc;
    logic [31:0] imm;
    logic [4:0] rd;
    logic ill;
    chk("id_valid", {31'd0, id_valid}, {31'd0, exp_valid});
    if (exp_valid) begin
      ref_decode(exp_instr, oc, imm, rd, ill);
      chk("id_opclass", 32'(id_opclass), 32'(oc));
      chk("id_imm", id_imm, imm);
      chk("id_rd", {27'd0, id_rd}, {27'd0, rd});
      chk("id_illegal", {31'd0, id_illegal}, {31'd0, ill});
      chk("id_pc", id_pc, exp_pc);
      chk("id_funct3", {29'd0, id_funct3}, {29'd0, exp_instr[14:12]});
      chk("id_funct7b5", {31'd0, id_funct7b5}, {31'd0, exp_instr[30]});
      chk("id_op_a", id_op_a, arch[exp_instr[19:15]]);
      chk("id_op_b", id_op_b, arch[exp_instr[24:20]]);
    end
  endtask

  // One clock: drive inputs, check combinational handshake/addresses, advance model, check bundle.
  task automatic cycle(input logic v, input logic [31:0] ins, input logic [31:0] pc,
                       input logic rdy, input logic fl, input logic we,
                       input logic [4:0] wa, input logic [31:0] wd);
    logic exp_rdy, ld;
    if_valid = v; if_instr = ins; if_pc = pc; id_ready = rdy; flush = fl;
    wb_wen = we; wb_wadd = wa; wb_wdata = wd;
    #1;
    exp_rdy = !exp_valid || rdy;
    ld = v && exp_rdy;
    chk("if_ready", {31'd0, if_ready}, {31'd0, exp_rdy});
    chk("rf_radd1", {27'd0, rf_radd1}, {27'd0, ld ? ins[19:15] : exp_instr[19:15]});
    chk("rf_radd2", {27'd0, rf_radd2}, {27'd0, ld ? ins[24:20] : exp_instr[24:20]});
    @(posedge clk);
    if (we && wa != 5'd0) arch[wa] = wd;
    if (fl) exp_valid = 1'b0;
    else if (ld) begin exp_valid = 1'b1; exp_instr = ins; exp_pc = pc; end
    else if (rdy) exp_valid = 1'b0;
    #1;
    check_bundle();
  endtask

  typedef struct {
    logic [31:0] instr;
    opclass_t    oc;
    logic [31:0] imm;
    logic [4:0]  rd;
    logic        ill;
  } tv_t;
  tv_t tv [15];

  logic [6:0] opc_tab [11];

  initial begin
    logic [31:0] ins;
    tv[0]  = '{32'hFFD00293, OC_OPIMM,   32'hFFFFFFFD, 5'd5,  1'b0};
    tv[1]  = '{32'hFE208CE3, OC_BRANCH,  32'hFFFFFFF8, 5'd0,  1'b0};
    tv[2]  = '{32'h123450B7, OC_LUI,     32'h12345000, 5'd1,  1'b0};
    tv[3]  = '{32'hFFFFF517, OC_AUIPC,   32'hFFFFF000, 5'd10, 1'b0};
    tv[4]  = '{32'h008000EF, OC_JAL,     32'h00000008, 5'd1,  1'b0};
    tv[5]  = '{32'hFFC08167, OC_JALR,    32'hFFFFFFFC, 5'd2,  1'b0};
    tv[6]  = '{32'h01012183, OC_LOAD,    32'h00000010, 5'd3,  1'b0};
    tv[7]  = '{32'hFE532E23, OC_STORE,   32'hFFFFFFFC, 5'd0,  1'b0};
    tv[8]  = '{32'h00738433, OC_OP,      32'h00000000, 5'd8,  1'b0};
    tv[9]  = '{32'h403100B3, OC_OP,      32'h00000000, 5'd1,  1'b0};
    tv[10] = '{32'h0FF0000F, OC_FENCE,   32'h00000000, 5'd0,  1'b0};
    tv[11] = '{32'h00000073, OC_SYSTEM,  32'h00000000, 5'd0,  1'b0};
    tv[12] = '{32'h00000000, OC_ILLEGAL, 32'h00000000, 5'd0,  1'b1};
    tv[13] = '{32'h0000007F, OC_ILLEGAL, 32'h00000000, 5'd0,  1'b1};
    tv[14] = '{32'h00000290, OC_ILLEGAL, 32'h00000000, 5'd0,  1'b1};
    opc_tab = '{7'h37, 7'h17, 7'h6F, 7'h67, 7'h63, 7'h03, 7'h23, 7'h13, 7'h33, 7'h0F, 7'h73};

    for (int i = 0; i < 32; i++) arch[i] = 32'h0;
    exp_valid = 1'b0; exp_instr = 32'h0; exp_pc = 32'h0;
    nrst = 1'b0; if_valid = 1'b0; if_instr = 32'h0; if_pc = 32'h0; flush = 1'b0;
    id_ready = 1'b0; wb_wen = 1'b0; wb_wadd = 5'd0; wb_wdata = 32'h0;

    #2;
    chk("rst id_valid", {31'd0, id_valid}, 32'd0);
    chk("rst id_pc", id_pc, 32'd0);
    chk("rst id_imm", id_imm, 32'd0);
    chk("rst id_rd", {27'd0, id_rd}, 32'd0);
    chk("rst id_opclass", 32'(id_opclass), 32'd0);
    chk("rst id_illegal", {31'd0, id_illegal}, 32'd0);
    chk("rst id_funct3", {29'd0, id_funct3}, 32'd0);
    @(posedge clk); #1; nrst = 1'b1;

    // Decode table, one instruction per cycle with execute always ready.
    for (int k = 0; k < 15; k++) begin
      cycle(1'b1, tv[k].instr, 32'h1000 + 32'(4 * k), 1'b1, 1'b0, 1'b0, 5'd0, 32'h0);
      chk("tv valid", {31'd0, id_valid}, 32'd1);
      chk("tv opclass", 32'(id_opclass), 32'(tv[k].oc));
      chk("tv imm", id_imm, tv[k].imm);
      chk("tv rd", {27'd0, id_rd}, {27'd0, tv[k].rd});
      chk("tv illegal", {31'd0, id_illegal}, {31'd0, tv[k].ill});
      if (k == 0) chk("addi op_a", id_op_a, 32'h0);
    end

    // Same-cycle writeback of x7 while add x8,x7,x7 is accepted.
    cycle(1'b1, 32'h00738433, 32'h2000, 1'b1, 1'b0, 1'b1, 5'd7, 32'h1234);
    chk("bypass op_a", id_op_a, 32'h1234);
    chk("bypass op_b", id_op_b, 32'h1234);

    // Three-cycle stall; x7 rewritten mid-stall.
    cycle(1'b1, 32'h123450B7, 32'h2004, 1'b0, 1'b0, 1'b0, 5'd0, 32'h0);
    cycle(1'b1, 32'h123450B7, 32'h2004, 1'b0, 1'b0, 1'b1, 5'd7, 32'h55);
    cycle(1'b1, 32'h123450B7, 32'h2004, 1'b0, 1'b0, 1'b0, 5'd0, 32'h0);
    chk("stall op_a", id_op_a, 32'h55);
    chk("stall op_b", id_op_b, 32'h55);
    chk("stall pc", id_pc, 32'h2000);
    chk("stall rd", {27'd0, id_rd}, 32'd8);

    // Flush with a simultaneous load, then a normal accept.
    cycle(1'b1, 32'h123450B7, 32'h2004, 1'b1, 1'b1, 1'b0, 5'd0, 32'h0);
    chk("flush valid", {31'd0, id_valid}, 32'd0);
    cycle(1'b1, 32'hFFD00293, 32'h3000, 1'b1, 1'b0, 1'b0, 5'd0, 32'h0);
    chk("post-flush opclass", 32'(id_opclass), 32'(OC_OPIMM));
    chk("post-flush imm", id_imm, 32'hFFFFFFFD);

    // x0 writeback must not bypass.
    cycle(1'b1, 32'hFFD00293, 32'h3004, 1'b1, 1'b0, 1'b1, 5'd0, 32'hDEAD);
    chk("x0 op_a", id_op_a, 32'h0);

    // Asynchronous reset in the middle of a stall.
    cycle(1'b1, 32'h00738433, 32'h4000, 1'b1, 1'b0, 1'b0, 5'd0, 32'h0);
    cycle(1'b1, 32'hFFD00293, 32'h4004, 1'b0, 1'b0, 1'b0, 5'd0, 32'h0);
    if_valid = 1'b0; wb_wen = 1'b0; flush = 1'b0;
    #2 nrst = 1'b0;
    #1;
    chk("async rst valid", {31'd0, id_valid}, 32'd0);
    chk("async rst pc", id_pc, 32'd0);
    exp_valid = 1'b0; exp_instr = 32'h0; exp_pc = 32'h0;
    @(posedge clk); #1; nrst = 1'b1;
    cycle(1'b1, 32'h01012183, 32'h5000, 1'b1, 1'b0, 1'b0, 5'd0, 32'h0);
    chk("post-rst valid", {31'd0, id_valid}, 32'd1);

    // Randomized traffic against the reference model.
    for (int n = 0; n < 500; n++) begin
      if ($urandom_range(0, 11) == 11) ins = $urandom;
      else ins = {$urandom} & 32'hFFFF_FF80 | {25'd0, opc_tab[$urandom_range(0, 10)]};
      ins[19:15] = 5'($urandom_range(0, 7));
      ins[24:20] = 5'($urandom_range(0, 7));
      cycle($urandom_range(0, 3) != 0, ins, $urandom, $urandom_range(0, 3) != 0,
            $urandom_range(0, 15) == 0, 1'($urandom_range(0, 1)),
            5'($urandom_range(0, 7)), $urandom);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
